// File: rtl/cfg_chain_pkg.sv
// Shared types and helpers for the configuration chain loader.
package cfg_chain_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLdWait,
        StLdShift,
        StRbShift,
        StRbOut,
        StFin
    } state_e;

    // Number of host bytes needed to cover a chain of the given length.
    function automatic int unsigned num_bytes(input int unsigned chain_len);
        return (chain_len + BYTE_W - 1) / BYTE_W;
    endfunction

    // Bits to move in the next byte slot: a full byte, or whatever is left.
    function automatic logic [3:0] chunk_bits(input int unsigned remaining);
        if (remaining >= BYTE_W) begin
            return 4'(BYTE_W);
        end
        return 4'(remaining);
    endfunction

endpackage

// File: rtl/cfg_byte_shifter.sv
// 8-bit shift register used both to serialise load bytes (MSB out) and to
// assemble readback bytes (LSB in). A per-byte counter flags the final bit.
module cfg_byte_shifter
    import cfg_chain_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         ser_in,
    input  logic [7:0]   par_in,
    input  logic [3:0]   nbits,
    output logic [7:0]   data,
    output logic         ser_out,
    output logic         last_bit
);

    logic [7:0] data_q;
    logic [3:0] cnt_q;
    logic [3:0] pad_q;
    logic [7:0] shifted;

    // Next value of the register for a single left shift.
    always_comb begin
        shifted = {data_q[6:0], ser_in};
    end

    // Parallel load sets the bit budget; the last shift of a short byte
    // left-justifies what was collected so the unused LSBs read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
            pad_q  <= '0;
        end else if (load) begin
            data_q <= par_in;
            cnt_q  <= nbits;
            pad_q  <= 4'(BYTE_W) - nbits;
        end else if (shift && (cnt_q != '0)) begin
            if (cnt_q == 4'd1) begin
                data_q <= shifted << pad_q;
            end else begin
                data_q <= shifted;
            end
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign data     = data_q;
    assign ser_out  = data_q[7];
    assign last_bit = (cnt_q == 4'd1);

endmodule

// File: rtl/cfg_chain_loader.sv
// Serial configuration chain driver: loads host bytes into the LUT chain or
// rotates the chain once to read it back without disturbing it.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       prog_clk,
    input  logic       prog_rst_n,
    input  logic       start_load,
    input  logic       start_rb,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       prog_en,
    output logic       prog_in,
    input  logic       prog_out,
    output logic       busy,
    output logic       done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bits_q, bits_d;

    logic       sh_load;
    logic       sh_shift;
    logic [7:0] sh_par;
    logic [3:0] sh_nbits;
    logic [7:0] sh_data;
    logic       sh_ser_out;
    logic       sh_last;

    cfg_byte_shifter u_shifter (
        .clk      (prog_clk),
        .rst_n    (prog_rst_n),
        .load     (sh_load),
        .shift    (sh_shift),
        .ser_in   (prog_out),
        .par_in   (sh_par),
        .nbits    (sh_nbits),
        .data     (sh_data),
        .ser_out  (sh_ser_out),
        .last_bit (sh_last)
    );

    // Next state, chain bit budget and byte shifter control.
    always_comb begin
        state_d  = state_q;
        bits_d   = bits_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_par   = '0;
        sh_nbits = chunk_bits(32'(bits_q));
        case (state_q)
            StIdle: begin
                // Load has priority when both starts arrive together.
                if (start_load) begin
                    state_d = StLdWait;
                    bits_d  = CNT_W'(CHAIN_LEN);
                end else if (start_rb) begin
                    state_d  = StRbShift;
                    bits_d   = CNT_W'(CHAIN_LEN);
                    sh_load  = 1'b1;
                    sh_nbits = chunk_bits(CHAIN_LEN);
                end
            end
            StLdWait: begin
                if (s_valid && s_ready) begin
                    state_d = StLdShift;
                    sh_load = 1'b1;
                    sh_par  = s_data;
                end
            end
            StLdShift: begin
                sh_shift = 1'b1;
                bits_d   = (bits_q != '0) ? bits_q - CNT_W'(1) : bits_q;
                if (sh_last) begin
                    state_d = (bits_q <= CNT_W'(1)) ? StFin : StLdWait;
                end
            end
            StRbShift: begin
                sh_shift = 1'b1;
                bits_d   = (bits_q != '0) ? bits_q - CNT_W'(1) : bits_q;
                if (sh_last) begin
                    state_d = StRbOut;
                end
            end
            StRbOut: begin
                if (m_ready) begin
                    if (bits_q == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StRbShift;
                        sh_load = 1'b1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state_q <= StIdle;
            bits_q  <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            prog_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            s_ready <= (state_d == StLdWait);
            m_valid <= (state_d == StRbOut);
            prog_en <= (state_d == StLdShift) || (state_d == StRbShift);
            busy    <= (state_d != StIdle);
            done    <= (state_d == StFin);
        end
    end

    // Readback feeds the chain tail straight back into its head.
    assign prog_in = (state_q == StRbShift) ? prog_out
                                            : ((state_q == StLdShift) && sh_ser_out);
    assign m_data  = m_valid ? sh_data : '0;

endmodule
